// File: rtl/usart_stream_buffer.sv
// Buffered byte router between the USART Rx/Tx cores: an RX FIFO and a TX FIFO feed
// a small transmit FSM. Host mode sends from the TX FIFO; loopback sends from the RX FIFO.
module usart_stream_buffer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_valid,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic [DATA_BITS-1:0] host_wr_data,
  input  logic                 host_wr_en,
  output logic                 host_wr_full,
  output logic [DATA_BITS-1:0] host_rd_data,
  input  logic                 host_rd_en,
  output logic                 host_rd_empty,
  output logic                 rx_overflow,
  input  logic                 clear_ovf,
  output logic [AW:0]          rx_count,
  output logic [AW:0]          tx_count
);

  localparam logic [AW:0] FullCnt = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StWaitHi, StWaitLo} state_e;

  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];

  logic [AW-1:0]        rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q;
  logic [AW:0]          rx_count_q, tx_count_q;
  logic                 rx_overflow_q;
  logic                 mode_q;
  state_e               state_q;
  logic [DATA_BITS-1:0] tx_data_q;
  logic                 tx_start_q;

  logic                 rx_full, rx_empty, tx_full, tx_empty;
  logic                 rx_push, rx_pop, tx_push, tx_pop;
  logic                 src_empty, fsm_pop;
  logic [DATA_BITS-1:0] rx_head, tx_head, src_head;

  always_comb begin
    rx_full   = (rx_count_q == FullCnt);
    rx_empty  = (rx_count_q == '0);
    tx_full   = (tx_count_q == FullCnt);
    tx_empty  = (tx_count_q == '0);
    rx_head   = rx_mem[rx_rptr_q];
    tx_head   = tx_mem[tx_rptr_q];
    src_empty = mode_q ? rx_empty : tx_empty;
    src_head  = mode_q ? rx_head : tx_head;
    fsm_pop   = (state_q == StIdle) && !src_empty && !tx_busy;
    // A full FIFO drops the push even when a pop frees a slot in the same cycle.
    rx_push   = rx_valid && !rx_full;
    tx_push   = host_wr_en && !tx_full;
    // The FSM owns the RX FIFO read port in loopback, so host reads are ignored there.
    rx_pop    = !rx_empty && (mode_q ? fsm_pop : host_rd_en);
    tx_pop    = !mode_q && fsm_pop;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
    if (tx_push) tx_mem[tx_wptr_q] <= host_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
      if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
      if (rx_push && !rx_pop)      rx_count_q <= rx_count_q + (AW+1)'(1);
      else if (!rx_push && rx_pop) rx_count_q <= rx_count_q - (AW+1)'(1);
      if (tx_push && !tx_pop)      tx_count_q <= tx_count_q + (AW+1)'(1);
      else if (!tx_push && tx_pop) tx_count_q <= tx_count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overflow_q <= 1'b0;
    end else if (rx_valid && rx_full) begin
      rx_overflow_q <= 1'b1;
    end else if (clear_ovf) begin
      rx_overflow_q <= 1'b0;
    end
  end

  // tx_start is registered: it is high for the one cycle after the FSM leaves StStart.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          mode_q <= mode;
          if (fsm_pop) begin
            tx_data_q <= src_head;
            state_q   <= StStart;
          end
        end
        StStart: begin
          tx_start_q <= 1'b1;
          state_q    <= StWaitHi;
        end
        StWaitHi: if (tx_busy)  state_q <= StWaitLo;
        StWaitLo: if (!tx_busy) state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;
  assign host_wr_full  = tx_full;
  assign host_rd_data  = rx_head;
  assign host_rd_empty = rx_empty;
  assign rx_overflow   = rx_overflow_q;
  assign rx_count      = rx_count_q;
  assign tx_count      = tx_count_q;

endmodule
